// File: rtl/laconic_term_scheduler_if.sv
// Group-in / term-pair-out bus between the producer, the term scheduler and the Laconic PE core.
`timescale 1ns/1ps
interface laconic_term_scheduler_if;
  localparam int unsigned LANES = 16;
  localparam int unsigned OPW   = 8;
  localparam int unsigned EXPW  = 3;

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*OPW-1:0]    act_in;
  logic [LANES*OPW-1:0]    wgt_in;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic [LANES-1:0]        in_applied;
  logic [LANES*EXPW-1:0]   t0;
  logic [LANES*EXPW-1:0]   t1;
  logic [LANES-1:0]        s0;
  logic [LANES-1:0]        s1;
  logic                    busy;

  // Producer/consumer side
  modport master (
    output in_valid, act_in, wgt_in, out_ready,
    input  in_ready, out_valid, out_last, in_applied, t0, t1, s0, s1, busy
  );

  // Scheduler side
  modport slave (
    input  in_valid, act_in, wgt_in, out_ready,
    output in_ready, out_valid, out_last, in_applied, t0, t1, s0, s1, busy
  );
endinterface

// File: rtl/laconic_term_scheduler.sv
// Recodes 16 activation/weight pairs to NAF terms and streams per-lane term cross products.
`timescale 1ns/1ps
module laconic_term_scheduler #(
  parameter int unsigned N = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  laconic_term_scheduler_if.slave   bus
);
  localparam int unsigned EW = 3;            // exponent width
  localparam int unsigned TW = 4 * (EW + 1); // four {sign, exponent} terms per operand
  localparam int unsigned CW = 3;            // term count 0..4 / act pointer 0..4

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              r_state;
  logic [TW-1:0]       r_a_terms [N];
  logic [TW-1:0]       r_w_terms [N];
  logic [CW-1:0]       r_na      [N];
  logic [CW-1:0]       r_nw      [N];
  logic [CW-1:0]       r_ai      [N];
  logic [1:0]          r_wi      [N];
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_busy;
  logic [N-1:0]        r_applied;
  logic [N-1:0]        r_s0;
  logic [N-1:0]        r_s1;
  logic [EW*N-1:0]     r_t0;
  logic [EW*N-1:0]     r_t1;

  logic [TW-1:0]       w_ld_a_terms [N];
  logic [TW-1:0]       w_ld_w_terms [N];
  logic [CW-1:0]       w_ld_na      [N];
  logic [CW-1:0]       w_ld_nw      [N];
  logic [CW-1:0]       w_adv_ai     [N];
  logic [1:0]          w_adv_wi     [N];
  logic [TW-1:0]       w_sel_a      [N];
  logic [TW-1:0]       w_sel_w      [N];
  logic [CW-1:0]       w_sel_na     [N];
  logic [CW-1:0]       w_sel_nw     [N];
  logic [CW-1:0]       w_sel_ai     [N];
  logic [1:0]          w_sel_wi     [N];
  logic                w_fire;
  logic                w_in_ready;
  logic                w_load;
  logic                w_any_more;
  logic                w_nxt_last;
  logic [N-1:0]        w_nxt_applied;
  logic [N-1:0]        w_nxt_s0;
  logic [N-1:0]        w_nxt_s1;
  logic [EW*N-1:0]     w_nxt_t0;
  logic [EW*N-1:0]     w_nxt_t1;

  // NAF recoding of |x|: returns {terms[15:0], count[2:0]}, term k = {sign, exponent} ascending
  function automatic logic [TW+CW-1:0] naf_terms(input logic [7:0] x);
    logic [8:0]    m;
    logic          neg;
    logic [CW-1:0] cnt;
    logic [TW-1:0] terms;
    neg   = x[7];
    m     = neg ? (9'd0 - {x[7], x}) : {1'b0, x};
    cnt   = '0;
    terms = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[0]) begin
        terms[{cnt[1:0], 2'b00} +: 4] = {neg ^ m[1], EW'(i)};
        m   = m[1] ? (m + 9'd1) : (m - 9'd1);
        cnt = cnt + CW'(1);
      end
      m = m >> 1;
    end
    return {terms, cnt};
  endfunction

  // Term lists for the group currently presented on the input bus
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      {w_ld_a_terms[i], w_ld_na[i]} = naf_terms(bus.act_in[8*i +: 8]);
      {w_ld_w_terms[i], w_ld_nw[i]} = naf_terms(bus.wgt_in[8*i +: 8]);
    end
  end

  // Handshake: accept in IDLE or on the consumed last beat, never while in reset
  always_comb begin
    w_fire     = r_out_valid & bus.out_ready;
    w_in_ready = rst & ((r_state == S_IDLE) | (w_fire & r_out_last));
    w_load     = bus.in_valid & w_in_ready;
  end

  assign bus.in_ready = w_in_ready;

  // Per-lane pointer step: wi ascends, wraps into the next activation term
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      w_adv_ai[i] = r_ai[i];
      w_adv_wi[i] = r_wi[i];
      if ((r_ai[i] < r_na[i]) && (r_nw[i] != '0)) begin
        if ((CW'({1'b0, r_wi[i]}) + CW'(1)) == r_nw[i]) begin
          w_adv_wi[i] = '0;
          w_adv_ai[i] = r_ai[i] + CW'(1);
        end else begin
          w_adv_wi[i] = r_wi[i] + 2'd1;
        end
      end
    end
  end

  // Next beat contents from either a freshly loaded group or the advanced pointers
  always_comb begin
    w_any_more    = 1'b0;
    w_nxt_applied = '0;
    w_nxt_s0      = '0;
    w_nxt_s1      = '0;
    w_nxt_t0      = '0;
    w_nxt_t1      = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_sel_a[i]  = w_load ? w_ld_a_terms[i] : r_a_terms[i];
      w_sel_w[i]  = w_load ? w_ld_w_terms[i] : r_w_terms[i];
      w_sel_na[i] = w_load ? w_ld_na[i]      : r_na[i];
      w_sel_nw[i] = w_load ? w_ld_nw[i]      : r_nw[i];
      w_sel_ai[i] = w_load ? '0              : w_adv_ai[i];
      w_sel_wi[i] = w_load ? '0              : w_adv_wi[i];
      if ((w_sel_ai[i] < w_sel_na[i]) && (w_sel_nw[i] != '0)) begin
        w_nxt_applied[i]      = 1'b1;
        w_nxt_t0[EW*i +: EW]  = w_sel_a[i][{w_sel_ai[i][1:0], 2'b00} +: EW];
        w_nxt_s0[i]           = w_sel_a[i][{w_sel_ai[i][1:0], 2'b11}];
        w_nxt_t1[EW*i +: EW]  = w_sel_w[i][{w_sel_wi[i], 2'b00} +: EW];
        w_nxt_s1[i]           = w_sel_w[i][{w_sel_wi[i], 2'b11}];
        if (((CW'({1'b0, w_sel_wi[i]}) + CW'(1)) < w_sel_nw[i]) ||
            ((w_sel_ai[i] + CW'(1)) < w_sel_na[i])) begin
          w_any_more = 1'b1;
        end
      end
    end
    w_nxt_last = ~w_any_more;
  end

  // State machine, term storage, pointers and registered beat outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_applied   <= '0;
      r_s0        <= '0;
      r_s1        <= '0;
      r_t0        <= '0;
      r_t1        <= '0;
      for (int i = 0; i < int'(N); i++) begin
        r_a_terms[i] <= '0;
        r_w_terms[i] <= '0;
        r_na[i]      <= '0;
        r_nw[i]      <= '0;
        r_ai[i]      <= '0;
        r_wi[i]      <= '0;
      end
    end else if (w_load) begin
      r_state     <= S_RUN;
      r_out_valid <= 1'b1;
      r_busy      <= 1'b1;
      r_out_last  <= w_nxt_last;
      r_applied   <= w_nxt_applied;
      r_s0        <= w_nxt_s0;
      r_s1        <= w_nxt_s1;
      r_t0        <= w_nxt_t0;
      r_t1        <= w_nxt_t1;
      for (int i = 0; i < int'(N); i++) begin
        r_a_terms[i] <= w_ld_a_terms[i];
        r_w_terms[i] <= w_ld_w_terms[i];
        r_na[i]      <= w_ld_na[i];
        r_nw[i]      <= w_ld_nw[i];
        r_ai[i]      <= '0;
        r_wi[i]      <= '0;
      end
    end else if (w_fire) begin
      if (r_out_last) begin
        r_state     <= S_IDLE;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_busy      <= 1'b0;
        r_applied   <= '0;
        r_s0        <= '0;
        r_s1        <= '0;
        r_t0        <= '0;
        r_t1        <= '0;
      end else begin
        r_out_last  <= w_nxt_last;
        r_applied   <= w_nxt_applied;
        r_s0        <= w_nxt_s0;
        r_s1        <= w_nxt_s1;
        r_t0        <= w_nxt_t0;
        r_t1        <= w_nxt_t1;
        for (int i = 0; i < int'(N); i++) begin
          r_ai[i] <= w_adv_ai[i];
          r_wi[i] <= w_adv_wi[i];
        end
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_last   = r_out_last;
  assign bus.busy       = r_busy;
  assign bus.in_applied = r_applied;
  assign bus.s0         = r_s0;
  assign bus.s1         = r_s1;
  assign bus.t0         = r_t0;
  assign bus.t1         = r_t1;
endmodule

// File: doc/laconic_term_scheduler.md
# laconic_term_scheduler

- Sits directly upstream of the Laconic PE core.
- Accepts one group of 16 signed 8-bit activation/weight pairs per handshake and recodes each operand into non-adjacent-form (NAF) signed power-of-two terms.
- Streams the per-lane cross product of activation terms × weight terms to the core, one term pair per lane per beat, in the core's native format: `in_applied`, packed 3-bit exponents `t0`/`t1`, sign bits `s0`/`s1`.
- Lanes run independently. A group ends when the lane with the most term pairs is exhausted; `out_last` marks that beat.

## Interface
Parameters:
- `N` (default 16): number of lanes. Fixed at 16; packing widths below assume it.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: group available on `act_in`/`wgt_in`.
- `in_ready` out 1: scheduler accepts a group this cycle.
- `act_in` in 128: lane i activation = `act_in[8i+7:8i]`, two's complement.
- `wgt_in` in 128: lane i weight = `wgt_in[8i+7:8i]`, two's complement.
- `out_valid` out 1: term-pair beat valid.
- `out_ready` in 1: downstream consumes the beat.
- `out_last` out 1: final beat of the group.
- `in_applied` out 16: lane i carries a term pair this beat.
- `t0` out 48: activation exponent, lane i = `t0[3i+2:3i]`.
- `t1` out 48: weight exponent, lane i = `t1[3i+2:3i]`.
- `s0` out 16: activation term sign, 1 = negative.
- `s1` out 16: weight term sign, 1 = negative.
- `busy` out 1: state is RUN.

## Operation
Recoding at accept:
- m = |x|, range 0..128. -128 gives m = 128.
- m is recoded to NAF: digits in {-1, 0, +1}, no two adjacent digits nonzero, positions 0..7.
- This gives at most 4 terms per operand.
- Terms are stored per lane in ascending exponent order: exponent (3 b), sign = operand sign XOR (digit < 0), count na / nw (0..4).
- Term value = (-1)^s · 2^t. The product sign s0^s1 matches the core.

State machine:
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` && `in_ready`: register the term lists, clear lane pointers (ai, wi) to 0, go to RUN.
- RUN:
  - `out_valid` = 1.
  - Lane i is active while pair (ai, wi) exists, i.e. ai < na and nw > 0.
  - `in_applied[i]` = active. `t0`/`s0` come from act term ai, `t1`/`s1` from weight term wi.
  - Inactive lanes drive t = 0, s = 0.
- Pair order per lane: ai-major, then wi ascending: (0,0), (0,1) … (0,nw-1), (1,0) …
- On `out_valid` && `out_ready`: each active lane advances wi; when wi wraps, wi = 0 and ai increments.
- `out_last` = 1 when no lane has a pair after this beat.
- On accepted `out_last`: go to IDLE. If `in_valid` is high in the same cycle, load the next group and stay in RUN.
- Group length = max(1, max over lanes of na·nw); range 1..16 beats.
- All-zero group (every lane na·nw = 0): exactly one beat with `in_applied` = 0 and `out_last` = 1.
- `in_ready` = (state == IDLE) || (`out_valid` && `out_ready` && `out_last`). This is the only combinational input-to-output path.
- `in_ready` is forced to 0 while `rst` is low.

## Timing
- Reset values: state IDLE, `out_valid` 0, `out_last` 0, `in_applied` 0, `t0`/`t1` 0, `s0`/`s1` 0, `busy` 0, all term registers and pointers 0.
- Latency: group accepted at edge k → first beat valid in the cycle after edge k.
- All beat outputs are driven from registers only; there is no path from `act_in`/`wgt_in` to them.
- Back-to-back groups have no bubble: the next group's first beat follows the previous `out_last` beat directly.
- Backpressure: while `out_ready` = 0, all outputs hold stable, pointers hold, and `in_ready` = 0.
- Reset mid-RUN: `out_valid` drops to 0 immediately (asynchronous) and the partial group is discarded. After release, the next accepted group starts cleanly.
- Throughput: 1 beat per cycle while `out_ready` = 1.

## Test plan
- **Unit operands.** All lanes act = 1, wgt = 1 → 1 beat: `in_applied` = 0xFFFF, `t0` = `t1` = 0, `s0` = `s1` = 0, `out_last` = 1. Core output = 16.
- **Single-lane NAF.** Lane 0 act = 3, wgt = -5, others 0 → 4 beats, `in_applied` = 0x0001 on each.
  - (t0, t1) sequence: (0,0), (0,2), (2,0), (2,2).
  - `s0` sequence: 1, 1, 0, 0. `s1` = 1 on all beats.
  - `out_last` on beat 4 only. Core outputs sum to -15.
- **All-zero and extremes.**
  - All-zero group → 1 beat, `in_applied` = 0, `out_last` = 1.
  - Lane 15 act = wgt = -128 → 1 beat: `t0[47:45]` = `t1[47:45]` = 7, `s0[15]` = `s1[15]` = 1.
  - Lane 0 act = wgt = 85 → 16 beats.
- **Backpressure.** `out_ready` = 0 for 3 cycles at beat 2 of the single-lane NAF case → outputs frozen, no pair skipped or repeated, `in_ready` = 0. Sum still -15.
- **Back-to-back groups.** `in_valid` held high across two groups → second group accepted on the first group's `out_last` beat; its first beat appears next cycle with no bubble.
- **Reset mid-RUN.** `rst` low during beat 3 of 16 → `out_valid` and `busy` drop asynchronously and `in_ready` = 0 while `rst` is low. After release: `in_ready` = 1, and a new unit-operand group yields exactly 1 correct beat.
